// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the arbiter state encoding and the default data-word width.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS = 8;
  localparam int MIN_CNT_BITS      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  // The start counter must reach timeout-1 and is never narrower than four bits.
  function automatic int cntWidth(input int timeout);
    int w;
    w = $clog2(timeout);
    return (w > MIN_CNT_BITS) ? w : MIN_CNT_BITS;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// at or after the pointer, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_idx
);

  logic [IDX_W-1:0] w_cand;

  // Scan from the farthest offset down to the pointer so the nearest hit is written last.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters,
// with a start handshake timeout when the transmitter never goes busy.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = DEFAULT_DATA_BITS,
  parameter int START_TIMEOUT = 16
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [NUM_REQ-1:0]           Req,
  input  logic [NUM_REQ*DATA_BITS-1:0] Req_Data,
  input  logic                         CTS,
  input  logic                         Tx_Busy,
  output logic [DATA_BITS-1:0]         Tx_Data,
  output logic                         Transmit_Start,
  output logic [NUM_REQ-1:0]           Grant,
  output logic [NUM_REQ-1:0]           Done,
  output logic [$clog2(NUM_REQ)-1:0]   Cur_Id,
  output logic                         Arb_Busy,
  output logic                         Start_Timeout
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = cntWidth(START_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

  arb_state_t r_state;
  arb_state_t w_nextState;

  logic [ID_W-1:0]      r_ptr;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_BITS-1:0] r_txData;
  logic [ID_W-1:0]      r_curId;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_timeout;

  logic                 w_pickValid;
  logic [ID_W-1:0]      w_pickIdx;
  logic [ID_W-1:0]      w_ptrNext;
  logic                 w_grantFire;
  logic                 w_frameDone;
  logic                 w_timeoutFire;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_pick (
    .i_req   (Req),
    .i_ptr   (r_ptr),
    .o_valid (w_pickValid),
    .o_idx   (w_pickIdx)
  );

  assign w_ptrNext = (w_pickIdx == ID_W'(NUM_REQ - 1)) ? '0 : w_pickIdx + ID_W'(1);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= IDLE;
    else      r_state <= w_nextState;
  end

  // Tx_Busy takes priority over the timeout so a late-but-valid start still proceeds.
  always_comb begin
    w_nextState   = r_state;
    w_grantFire   = 1'b0;
    w_frameDone   = 1'b0;
    w_timeoutFire = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pickValid && CTS && !Tx_Busy) begin
          w_nextState = START;
          w_grantFire = 1'b1;
        end
      end
      START: begin
        if (Tx_Busy) begin
          w_nextState = BUSY;
        end else if (r_cnt == CNT_LAST) begin
          w_nextState   = IDLE;
          w_timeoutFire = 1'b1;
        end
      end
      BUSY: begin
        if (!Tx_Busy) begin
          w_nextState = IDLE;
          w_frameDone = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_txData  <= '0;
      r_curId   <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_grant   <= '0;
      r_done    <= '0;
      r_timeout <= w_timeoutFire;
      if (r_state == START) r_cnt <= r_cnt + CNT_W'(1);
      else                  r_cnt <= '0;
      if (w_grantFire) begin
        r_txData <= Req_Data[w_pickIdx*DATA_BITS +: DATA_BITS];
        r_curId  <= w_pickIdx;
        r_grant  <= NUM_REQ'(1) << w_pickIdx;
        r_ptr    <= w_ptrNext;
      end
      if (w_frameDone) r_done <= NUM_REQ'(1) << r_curId;
    end
  end

  assign Tx_Data        = r_txData;
  assign Cur_Id         = r_curId;
  assign Grant          = r_grant;
  assign Done           = r_done;
  assign Start_Timeout  = r_timeout;
  assign Transmit_Start = (r_state == START);
  assign Arb_Busy       = (r_state != IDLE);

endmodule
